// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text path: display line type,
// ASCII constants, formatter state encoding and the BCD adjust helper.
package lcd_pkg;

    typedef logic [0:31][7:0] lcd_line_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2
    } fmt_state_t;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
        logic [19:0] adj;
        logic [3:0]  nib;
        adj = 20'd0;
        for (int i = 0; i < 5; i++) begin
            nib = bcd[4*i +: 4];
            if (nib >= 4'd5) begin
                adj[4*i +: 4] = nib + 4'd3;
            end else begin
                adj[4*i +: 4] = nib;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/lcd_bin2bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter, one bit per clock.
// done is high during the cycle whose closing edge performs the 16th shift.
module lcd_bin2bcd
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic        done
);

    logic [19:0] bcd_r;
    logic [15:0] shift_r;
    logic [3:0]  cnt_r;
    logic        active_r;
    logic        done_r;
    logic [19:0] adj_s;

    // Nibble correction applied ahead of each shift
    always_comb begin
        adj_s = bcd_adjust(bcd_r);
    end

    // Conversion shift register and cycle counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            bcd_r    <= 20'd0;
            shift_r  <= 16'd0;
            cnt_r    <= 4'd0;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            bcd_r    <= 20'd0;
            shift_r  <= bin;
            cnt_r    <= 4'd0;
            active_r <= 1'b1;
            done_r   <= 1'b0;
        end else if (active_r) begin
            bcd_r    <= {adj_s[18:0], shift_r[15]};
            shift_r  <= {shift_r[14:0], 1'b0};
            cnt_r    <= cnt_r + 4'd1;
            active_r <= (cnt_r != 4'd15);
            done_r   <= (cnt_r == 4'd14);
        end else begin
            done_r   <= 1'b0;
        end
    end

    assign bcd  = bcd_r;
    assign done = done_r;

endmodule

// File: rtl/lcd_text_builder.sv
// 32-character display buffer fed by a direct write port and a decimal
// number formatter that writes 5 ASCII digits starting at a chosen index.
module lcd_text_builder
    import lcd_pkg::*;
#(
    parameter int         BLANK_ZEROS = 1,
    parameter logic [7:0] RESET_CHAR  = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        start,
    input  logic [15:0] value,
    input  logic [4:0]  field_pos,
    output logic        busy,
    output logic        done,
    output lcd_line_t   ASCII
);

    fmt_state_t  state_r, state_nx_s;
    logic [2:0]  k_r, k_nx_s;
    logic [4:0]  pos_r;
    logic        busy_r, busy_nx_s;
    logic        done_r, done_nx_s;
    logic        accept_s;
    logic        fmt_we_s;
    logic [4:0]  fmt_addr_s;
    logic [7:0]  fmt_char_s;
    logic [19:0] bcd_s;
    logic        conv_done_s;
    lcd_line_t   ascii_r;

    // Digit k of the BCD word; leading zeros may be shown as blanks
    function automatic logic [7:0] digit_char(input logic [19:0] bcd,
                                              input logic [2:0]  k,
                                              input logic        blank_en);
        logic [3:0] nib;
        logic       upper_zero;
        nib        = bcd[{k, 2'b00} +: 4];
        upper_zero = ((bcd >> ({k, 2'b00} + 5'd4)) == 20'd0);
        if (blank_en && (nib == 4'd0) && upper_zero && (k != 3'd0)) begin
            return ASCII_SPACE;
        end else begin
            return ASCII_ZERO + {4'd0, nib};
        end
    endfunction

    lcd_bin2bcd u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept_s),
        .bin   (value),
        .bcd   (bcd_s),
        .done  (conv_done_s)
    );

    // Formatter next-state and write-phase decode
    always_comb begin
        state_nx_s = state_r;
        k_nx_s     = k_r;
        busy_nx_s  = busy_r;
        done_nx_s  = 1'b0;
        accept_s   = 1'b0;
        fmt_we_s   = 1'b0;
        fmt_addr_s = pos_r + {2'b00, 3'd4 - k_r};
        fmt_char_s = digit_char(bcd_s, k_r, BLANK_ZEROS != 0);
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_nx_s = CONV;
                    k_nx_s     = 3'd4;
                    busy_nx_s  = 1'b1;
                end else begin
                    busy_nx_s  = 1'b0;
                end
            end
            CONV: begin
                if (conv_done_s) begin
                    state_nx_s = WRITE;
                end else begin
                    state_nx_s = CONV;
                end
            end
            WRITE: begin
                fmt_we_s = 1'b1;
                if (k_r == 3'd0) begin
                    state_nx_s = IDLE;
                    busy_nx_s  = 1'b0;
                    done_nx_s  = 1'b1;
                end else begin
                    k_nx_s     = k_r - 3'd1;
                end
            end
            default: begin
                state_nx_s = IDLE;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // Formatter state, digit index and status registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            k_r     <= 3'd0;
            pos_r   <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            k_r     <= k_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
            if (accept_s) begin
                pos_r <= field_pos;
            end else begin
                pos_r <= pos_r;
            end
        end
    end

    // Display buffer; the later formatter assignment wins an index collision
    always_ff @(posedge clk) begin
        if (!reset) begin
            ascii_r <= {32{RESET_CHAR}};
        end else begin
            if (wr_en) begin
                ascii_r[wr_addr] <= wr_data;
            end
            if (fmt_we_s) begin
                ascii_r[fmt_addr_s] <= fmt_char_s;
            end
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign ASCII = ascii_r;

endmodule

// File: tb/tb_lcd_text_builder.sv
// Randomised and directed bench for lcd_text_builder against a cycle-level
// behavioural model of the buffer and the decimal formatter.
module tb_lcd_text_builder;
    import lcd_pkg::*;

    localparam int TB_BLANK = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic [15:0] value;
    logic [4:0]  field_pos;
    logic        busy;
    logic        done;
    lcd_line_t   ascii_s;

    int checks = 0;
    int errors = 0;

    lcd_line_t   exp_line;
    bit          exp_busy = 1'b0;
    bit          exp_done = 1'b0;
    bit          mdl_valid = 1'b0;
    int unsigned m_t = 0;
    int unsigned m_val = 0;
    int unsigned m_pos = 0;

    lcd_text_builder #(.BLANK_ZEROS(TB_BLANK), .RESET_CHAR(8'h20)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .value     (value),
        .field_pos (field_pos),
        .busy      (busy),
        .done      (done),
        .ASCII     (ascii_s)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // j = 0 is the most significant of the 5 decimal digits
    function automatic logic [7:0] exp_digit(input int unsigned v, input int j);
        int unsigned p;
        int unsigned d;
        p = 1;
        for (int i = 0; i < 4 - j; i++) p = p * 10;
        d = (v / p) % 10;
        if (TB_BLANK != 0 && j < 4 && v < p) return 8'h20;
        return 8'h30 + 8'(d);
    endfunction

    // Model: t counts edges since the accepted start; digits land on t = 17..21
    initial begin
        int unsigned prev;
        forever begin
            @(posedge clk);
            if (reset === 1'b0) begin
                exp_line  = {32{8'h20}};
                m_t       = 0;
                exp_busy  = 1'b0;
                exp_done  = 1'b0;
                mdl_valid = 1'b1;
            end else begin
                prev     = m_t;
                exp_done = (prev == 21);
                if (wr_en) exp_line[wr_addr] = wr_data;
                if (prev >= 17) exp_line[(m_pos + prev - 17) % 32] = exp_digit(m_val, int'(prev) - 17);
                if (prev == 0) begin
                    if (start) begin
                        m_val = value;
                        m_pos = field_pos;
                        m_t   = 1;
                    end
                end else if (prev == 21) begin
                    m_t = 0;
                end else begin
                    m_t = prev + 1;
                end
                exp_busy = (m_t != 0);
            end
        end
    end

    // Compare DUT against the model every cycle once reset has been seen
    initial begin
        forever begin
            @(negedge clk);
            if (mdl_valid) begin
                checks++;
                if (ascii_s !== exp_line) begin
                    int bad;
                    bad = 0;
                    for (int i = 31; i >= 0; i--) if (ascii_s[i] !== exp_line[i]) bad = i;
                    errors++;
                    $display("FAIL ascii[%0d] got %h want %h", bad, ascii_s[bad], exp_line[bad]);
                end
                chk("busy", {31'd0, busy}, {31'd0, exp_busy});
                chk("done", {31'd0, done}, {31'd0, exp_done});
            end
        end
    end

    task automatic run_fmt(input logic [15:0] v, input logic [4:0] p, input bit coll,
                           input bit extra_start, output int busy_cnt,
                           output int done_cnt, output int done_at);
        @(negedge clk);
        start = 1'b1; value = v; field_pos = p;
        @(negedge clk);
        start = 1'b0; value = 16'($urandom); field_pos = 5'($urandom);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 1; c <= 30; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            wr_en   = coll && (c == 19);
            wr_addr = p + 5'd2;
            wr_data = 8'h58;
            start   = extra_start && (c == 6);
            @(negedge clk);
        end
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic pin5(input string name, input int p, input logic [39:0] want);
        logic [39:0] w;
        w = want;
        for (int j = 0; j < 5; j++)
            chk(name, {24'd0, ascii_s[(p + j) % 32]}, {24'd0, w[39 - 8*j -: 8]});
    endtask

    initial begin
        int bc, dc, da, dcount;
        reset = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'd0;
        start = 1'b0; value = 16'd0; field_pos = 5'd0;
        repeat (2) @(negedge clk);
        chk("rst_ascii0", {24'd0, ascii_s[0]}, 32'h20);
        chk("rst_ascii31", {24'd0, ascii_s[31]}, 32'h20);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h41;
        @(negedge clk);
        wr_en = 1'b0;
        chk("direct_wr5", {24'd0, ascii_s[5]}, 32'h41);

        run_fmt(16'd12345, 5'd0, 1'b1, 1'b1, bc, dc, da);
        chk("busy_cycles", bc, 32'd21);
        chk("done_count", dc, 32'd1);
        chk("done_cycle", da, 32'd22);
        pin5("fmt_12345", 0, 40'h3132333435);
        chk("keep_wr5", {24'd0, ascii_s[5]}, 32'h41);

        run_fmt(16'd7, 5'd16, 1'b0, 1'b0, bc, dc, da);
        pin5("blank_7", 16, 40'h2020202037);
        run_fmt(16'd0, 5'd16, 1'b0, 1'b0, bc, dc, da);
        pin5("blank_0", 16, 40'h2020202030);
        run_fmt(16'd65535, 5'd30, 1'b0, 1'b0, bc, dc, da);
        pin5("wrap_65535", 30, 40'h3635353335);

        // Reset five cycles into CONV abandons the conversion
        @(negedge clk);
        start = 1'b1; value = 16'd999; field_pos = 5'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ascii0", {24'd0, ascii_s[0]}, 32'h20);
        dcount = 0;
        for (int c = 0; c < 25; c++) begin
            if (done === 1'b1) dcount++;
            @(negedge clk);
        end
        chk("midrst_nodone", dcount, 32'd0);
        run_fmt(16'd4321, 5'd10, 1'b0, 1'b0, bc, dc, da);
        chk("after_rst_done", dc, 32'd1);
        pin5("fmt_4321", 10, 40'h2034333231);

        // Start presented in the done cycle is accepted
        start = 1'b1; value = 16'd500; field_pos = 5'd20;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int c = 0; c < 30 && dcount == 0; c++) begin
            if (done === 1'b1) begin
                dcount = 1;
                start = 1'b1; value = 16'd42; field_pos = 5'd3;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", dcount, 32'd1);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        repeat (25) @(negedge clk);
        pin5("fmt_42", 3, 40'h2020203432);

        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 199) != 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 5'($urandom);
            wr_data   = 8'($urandom);
            start     = ($urandom_range(0, 7) == 0);
            value     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom);
            field_pos = 5'($urandom);
            @(negedge clk);
        end
        reset = 1'b1; wr_en = 1'b0; start = 1'b0;
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_text_builder.md
Name: lcd_text_builder

Overview:
- Upstream feeder for the LCD driver. It owns the 32-character ASCII display buffer that the driver continuously scans out.
- The buffer is written in two ways: by a direct single-character write port, or by a sequential number formatter. The formatter converts a 16-bit unsigned value to 5 decimal ASCII digits and stores them at a chosen buffer position.
- Line 1 is buffer entries 0..15 and line 2 is entries 16..31.

Parameters:
- BLANK_ZEROS, 1, 1 = leading zeros of a formatted number are written as space (8'h20); the least significant digit is always a digit. 0 = all 5 digits written.
- RESET_CHAR, 8'h20, value loaded into every buffer entry on reset.

Ports:
- clk  input  1  master 50 MHz clock
- reset  input  1  active-low reset
- wr_en  input  1  direct character write strobe
- wr_addr  input  5  direct write buffer index 0..31
- wr_data  input  8  direct write ASCII code
- start  input  1  formatter request, sampled only in IDLE
- value  input  16  unsigned number to format, captured on accepted start
- field_pos  input  5  buffer index of the most significant digit, captured on accepted start
- busy  output  1  formatter active
- done  output  1  one-cycle pulse when all 5 digits have been written
- ASCII  output  [0:31][7:0]  display buffer, drives the LCD driver's ASCII input

Behaviour:
- Reset: one clock, synchronous and active-low; reset is sampled on posedge clk only.
  - On reset, all ASCII entries = RESET_CHAR, busy=0, done=0, state=IDLE, and internal BCD and shift registers are cleared.
  - Reset overrides every other input in the same cycle.
- Direct write: if wr_en=1 at a posedge, then ASCII[wr_addr] <= wr_data.
  - Accepted in every state, with 1-cycle latency.
- FSM states: IDLE, CONV, WRITE.
  - IDLE: start=1 at edge N captures value, field_pos and digit index k=4, clears BCD to 0, and moves to CONV. busy=1 from edge N.
  - CONV: double-dabble, one bit per cycle, on edges N+1..N+16.
    - Each cycle: every BCD nibble >= 5 gets +3, then {bcd[19:0], shift[15:0]} shifts left by 1.
    - BCD is 20 bits (5 nibbles). The maximum value 65535 fits without overflow.
    - After 16 shifts the FSM moves to WRITE.
  - WRITE: edges N+17..N+21 write digit k (k = 4 down to 0, most significant first) to ASCII[(field_pos + 4 - k) mod 32].
    - Address arithmetic is 5-bit and wraps naturally: position 31 is followed by 0.
    - Character = 8'h30 + nibble, or 8'h20 when BLANK_ZEROS=1, the nibble is 0, all higher nibbles are 0, and k != 0.
  - After the edge N+21 write, the FSM returns to IDLE with busy=0. done=1 for exactly the cycle after edge N+21.
  - Total: busy is high for 21 cycles, and done follows immediately.
- start while busy is ignored; it is not queued. start coinciding with the done cycle is accepted normally, and done still pulses.
- value and field_pos may change freely after the accepted start.
- Collision: a direct write and a formatter write to the same index in the same cycle → the formatter write wins. A direct write to a different index in that cycle still takes effect.
- Reset asserted mid-CONV or mid-WRITE: the conversion is abandoned, the whole buffer returns to RESET_CHAR, and no done pulse is produced.
- The ASCII output is registered with no combinational path from inputs. Entries not written keep their value indefinitely.

Decomposition:
- Package lcd_pkg holds:
  - typedef lcd_line_t = logic [0:31][7:0];
  - constants ASCII_SPACE=8'h20 and ASCII_ZERO=8'h30;
  - the formatter state enum {IDLE, CONV, WRITE}.
- The LCD driver imports lcd_line_t from the same package.
- One sub-module: lcd_bin2bcd, the sequential 16-bit to 5-digit double-dabble.
  - Ports: clk, reset, start, bin[15:0], bcd[19:0], done.
  - Fixed 16-cycle latency.
  - The top level sequences it and performs the WRITE phase.

Test Plan:
- Reset: hold reset=0 for 2 cycles → all 32 ASCII entries = 8'h20, busy=0, done=0. Release reset, then wr_en=1, wr_addr=5, wr_data=8'h41 → ASCII[5]=8'h41 on the next cycle.
- Format 12345 at field_pos=0 → busy high for 21 cycles, done pulses on cycle 22, ASCII[0..4]=31,32,33,34,35 (hex), all other entries unchanged.
- BLANK_ZEROS=1, value=7, field_pos=16 → ASCII[16..20]=20,20,20,20,37. Repeat with value=0 → ASCII[16..20]=20,20,20,20,30.
- Wrap: value=65535, field_pos=30 → ASCII[30]=36, ASCII[31]=35, ASCII[0]=35, ASCII[1]=33, ASCII[2]=35.
- Collision and ignore: during WRITE of 12345 at pos 0, drive wr_en to address 2 with 8'h58 on the edge that writes index 2 → ASCII[2]=33 (formatter wins). A second start pulse while busy → no extra conversion, exactly one done pulse.
- Reset mid-operation: assert reset=0 five cycles into CONV → buffer all 8'h20, busy=0, and no done pulse. A new start after release completes normally.
